// File: rtl/trace_debugger_if.sv
// Packet stream from the trace encoder toward trace storage.
// A packet transfers on a rising edge where packet_valid_o && packet_ready_i; while valid is
// high and ready is low, packet_o holds stable and valid stays high.
interface trace_debugger_if;
    logic [79:0] packet_o;
    logic        packet_valid_o;
    logic        packet_ready_i;

    modport master (output packet_o, output packet_valid_o, input packet_ready_i);
    modport slave  (input packet_o, input packet_valid_o, output packet_ready_i);
endinterface

// File: rtl/trace_debugger.sv
// RISC-V retirement-port trace encoder: compresses retired instructions into start, branch-map,
// address and exception packets, buffered in a small FIFO drained over a valid/ready port.
module trace_debugger #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             trace_enable_i,
    input  logic             ivalid_i,
    input  logic             iexception_i,
    input  logic             interrupt_i,
    input  logic [4:0]       cause_i,
    input  logic [31:0]      tval_i,
    input  logic [2:0]       priv_i,
    input  logic [31:0]      iaddr_i,
    input  logic [31:0]      instr_i,
    input  logic             compressed_i,
    trace_debugger_if.master pkt,
    output logic             overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] PKT_FULL  = 2'b00;
    localparam logic [1:0] PKT_ADDR  = 2'b01;
    localparam logic [1:0] PKT_START = 2'b10;
    localparam logic [1:0] PKT_EXC   = 2'b11;

    logic        prev_valid_q, prev_valid_d;
    logic [31:0] prev_addr_q, prev_addr_d;
    logic        prev_compressed_q, prev_compressed_d;
    logic        prev_branch_q, prev_branch_d;
    logic        prev_uninf_q, prev_uninf_d;
    logic [4:0]  count_q, count_d;
    logic [30:0] map_q, map_d;
    logic        start_pending_q, start_pending_d;

    logic        is_branch, is_uninf, not_taken;
    logic [4:0]  count_upd;
    logic [30:0] map_upd;
    logic        push;
    logic [79:0] push_pkt;

    // Compressed forms are only recognised when the core flags a 16-bit instruction.
    always_comb begin
        if (compressed_i) begin
            is_branch = (instr_i[1:0] == 2'b01) && (instr_i[15:14] == 2'b11);
            is_uninf  = (instr_i[1:0] == 2'b10) && (instr_i[15:13] == 3'b100) &&
                        (instr_i[6:2] == 5'd0) && (instr_i[11:7] != 5'd0);
        end else begin
            is_branch = (instr_i[6:0] == 7'b1100011);
            is_uninf  = (instr_i[6:0] == 7'b1100111) || (instr_i == 32'h3020_0073);
        end
    end

    always_comb begin
        prev_valid_d      = prev_valid_q;
        prev_addr_d       = prev_addr_q;
        prev_compressed_d = prev_compressed_q;
        prev_branch_d     = prev_branch_q;
        prev_uninf_d      = prev_uninf_q;
        count_d           = count_q;
        map_d             = map_q;
        start_pending_d   = start_pending_q;
        not_taken         = 1'b0;
        count_upd         = count_q;
        map_upd           = map_q;
        push              = 1'b0;
        push_pkt          = '0;
        if (!trace_enable_i) begin
            prev_valid_d    = 1'b0;
            count_d         = 5'd0;
            map_d           = 31'd0;
            start_pending_d = 1'b1;
        end else if (ivalid_i) begin
            // Resolve the previous branch by checking whether this instruction is its fall-through.
            if (prev_valid_q && prev_branch_q) begin
                not_taken = (iaddr_i == prev_addr_q + (prev_compressed_q ? 32'd2 : 32'd4));
                map_upd   = map_q | ({30'd0, not_taken} << count_q);
                count_upd = count_q + 5'd1;
            end
            count_d = count_upd;
            map_d   = map_upd;
            if (iexception_i) begin
                push            = 1'b1;
                push_pkt        = {4'd0, tval_i, cause_i, interrupt_i, map_upd, count_upd, PKT_EXC};
                count_d         = 5'd0;
                map_d           = 31'd0;
                prev_valid_d    = 1'b0;
                start_pending_d = 1'b1;
            end else begin
                if (start_pending_q) begin
                    push            = 1'b1;
                    push_pkt        = {43'd0, iaddr_i, priv_i, PKT_START};
                    start_pending_d = 1'b0;
                end else if (prev_valid_q && prev_uninf_q) begin
                    push     = 1'b1;
                    push_pkt = {10'd0, iaddr_i, map_upd, count_upd, PKT_ADDR};
                    count_d  = 5'd0;
                    map_d    = 31'd0;
                end else if (count_upd == 5'd31) begin
                    push     = 1'b1;
                    push_pkt = {42'd0, map_upd, 5'd31, PKT_FULL};
                    count_d  = 5'd0;
                    map_d    = 31'd0;
                end
                prev_valid_d      = 1'b1;
                prev_addr_d       = iaddr_i;
                prev_compressed_d = compressed_i;
                prev_branch_d     = is_branch;
                prev_uninf_d      = is_uninf;
            end
        end
    end

    logic [79:0]   mem_q [FIFO_DEPTH];
    logic [79:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          pop, do_push, full;

    assign pkt.packet_valid_o = (cnt_q != '0);
    assign pkt.packet_o       = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign overflow_o         = overflow_q;
    assign full               = (cnt_q == CW'(FIFO_DEPTH));
    assign pop                = pkt.packet_valid_o && pkt.packet_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push            = push && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (push && !do_push);
        if (do_push) begin
            mem_d[wr_q] = push_pkt;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        if (do_push && !pop) cnt_d = cnt_q + CW'(1);
        else if (!do_push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_valid_q      <= 1'b0;
            prev_addr_q       <= 32'd0;
            prev_compressed_q <= 1'b0;
            prev_branch_q     <= 1'b0;
            prev_uninf_q      <= 1'b0;
            count_q           <= 5'd0;
            map_q             <= 31'd0;
            start_pending_q   <= 1'b1;
            mem_q             <= '{default: '0};
            wr_q              <= '0;
            rd_q              <= '0;
            cnt_q             <= '0;
            overflow_q        <= 1'b0;
        end else begin
            prev_valid_q      <= prev_valid_d;
            prev_addr_q       <= prev_addr_d;
            prev_compressed_q <= prev_compressed_d;
            prev_branch_q     <= prev_branch_d;
            prev_uninf_q      <= prev_uninf_d;
            count_q           <= count_d;
            map_q             <= map_d;
            start_pending_q   <= start_pending_d;
            mem_q             <= mem_d;
            wr_q              <= wr_d;
            rd_q              <= rd_d;
            cnt_q             <= cnt_d;
            overflow_q        <= overflow_d;
        end
    end
endmodule

// File: tb/tb_trace_debugger.sv
// Directed bench for trace_debugger: expected packets are queued as stimulus is issued and
// compared in order by a monitor whenever a packet transfers.
module tb_trace_debugger;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] JALR = 32'h0000_8067;
    localparam logic [31:0] CBEQZ = 32'h0000_C001;
    localparam logic [31:0] CJR  = 32'h0000_8082;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic        ivalid = 1'b0;
    logic        iexception = 1'b0;
    logic        interrupt = 1'b0;
    logic [4:0]  cause = 5'd0;
    logic [31:0] tval = 32'd0;
    logic [2:0]  priv = 3'd0;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] instr = 32'd0;
    logic        compressed = 1'b0;
    logic        overflow;

    logic [79:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    trace_debugger_if pkt_if ();

    trace_debugger #(.FIFO_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .trace_enable_i (trace_enable),
        .ivalid_i       (ivalid),
        .iexception_i   (iexception),
        .interrupt_i    (interrupt),
        .cause_i        (cause),
        .tval_i         (tval),
        .priv_i         (priv),
        .iaddr_i        (iaddr),
        .instr_i        (instr),
        .compressed_i   (compressed),
        .pkt            (pkt_if),
        .overflow_o     (overflow)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected-packet builders, written from the packet field layout
    function automatic logic [79:0] mk_start(input logic [31:0] addr, input logic [2:0] p);
        logic [79:0] r = '0;
        r[1:0] = 2'b10; r[4:2] = p; r[36:5] = addr;
        return r;
    endfunction

    function automatic logic [79:0] mk_addr(input logic [4:0] c, input logic [30:0] m, input logic [31:0] addr);
        logic [79:0] r = '0;
        r[1:0] = 2'b01; r[6:2] = c; r[37:7] = m; r[69:38] = addr;
        return r;
    endfunction

    function automatic logic [79:0] mk_full(input logic [30:0] m);
        logic [79:0] r = '0;
        r[1:0] = 2'b00; r[6:2] = 5'd31; r[37:7] = m;
        return r;
    endfunction

    function automatic logic [79:0] mk_exc(input logic [4:0] c, input logic [30:0] m, input logic intr,
                                           input logic [4:0] cs, input logic [31:0] tv);
        logic [79:0] r = '0;
        r[1:0] = 2'b11; r[6:2] = c; r[37:7] = m; r[38] = intr; r[43:39] = cs; r[75:44] = tv;
        return r;
    endfunction

    // Driver tasks
    task automatic retire(input logic [31:0] addr, input logic [31:0] ins, input logic c,
                          input logic [2:0] p, input logic exc);
        ivalid = 1'b1; iaddr = addr; instr = ins; compressed = c; priv = p; iexception = exc;
        tick();
        ivalid = 1'b0; iexception = 1'b0;
    endtask

    task automatic restart_start(input logic [31:0] addr, input logic [2:0] p, input bit expect_it);
        trace_enable = 1'b0;
        tick();
        trace_enable = 1'b1;
        if (expect_it) exp_q.push_back(mk_start(addr, p));
        retire(addr, NOP, 1'b0, p, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int i = 0;
        while (pkt_if.packet_valid_o && i < 64) begin
            tick();
            i++;
        end
        tick();
        check(name, {78'd0, pkt_if.packet_valid_o, 1'b0} | 80'(exp_q.size() << 2), 80'd0);
    endtask

    // Scoreboard monitor: a transfer seen between edges completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && pkt_if.packet_valid_o && pkt_if.packet_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_packet: got %h expected none", pkt_if.packet_o);
            end else begin
                check("packet", pkt_if.packet_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        pkt_if.packet_ready_i = 1'b1;
        tick();
        tick();
        check("reset_valid", 80'(pkt_if.packet_valid_o), 80'd0);
        check("reset_packet", pkt_if.packet_o, 80'd0);
        check("reset_overflow", 80'(overflow), 80'd0);
        rst_n = 1'b1;
        trace_enable = 1'b1;
        tick();

        exp_q.push_back(mk_start(32'h8000_0000, 3'd3));
        retire(32'h8000_0000, NOP, 1'b0, 3'd3, 1'b0);
        check("start_latency", 80'(pkt_if.packet_valid_o), 80'd1);

        retire(32'h0000_0100, BEQ, 1'b0, 3'd3, 1'b0);
        retire(32'h0000_0104, BEQ, 1'b0, 3'd3, 1'b0);
        retire(32'h0000_0200, JALR, 1'b0, 3'd3, 1'b0);
        exp_q.push_back(mk_addr(5'd2, 31'b01, 32'h0000_0400));
        retire(32'h0000_0400, NOP, 1'b0, 3'd3, 1'b0);

        for (int i = 0; i < 31; i++) retire(32'h0000_0404 + 32'(4 * i), BEQ, 1'b0, 3'd3, 1'b0);
        exp_q.push_back(mk_full(31'h7FFF_FFFF));
        retire(32'h0000_0480, NOP, 1'b0, 3'd3, 1'b0);

        retire(32'h0000_0484, BEQ, 1'b0, 3'd3, 1'b0);
        cause = 5'd2; tval = 32'h0000_DEAD; interrupt = 1'b0;
        exp_q.push_back(mk_exc(5'd1, 31'd1, 1'b0, 5'd2, 32'h0000_DEAD));
        retire(32'h0000_0488, NOP, 1'b0, 3'd3, 1'b1);
        exp_q.push_back(mk_start(32'h0000_0008, 3'd3));
        retire(32'h0000_0008, NOP, 1'b0, 3'd3, 1'b0);

        retire(32'h0000_000C, CBEQZ, 1'b1, 3'd3, 1'b0);
        retire(32'h0000_000E, CJR, 1'b1, 3'd3, 1'b0);
        exp_q.push_back(mk_addr(5'd1, 31'd1, 32'h0000_0040));
        retire(32'h0000_0040, NOP, 1'b0, 3'd3, 1'b0);
        wait_drain("drain_main");
        check("no_overflow_yet", 80'(overflow), 80'd0);

        pkt_if.packet_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) restart_start(32'h0000_1000 + 32'(16 * k), 3'(k), k < 4);
        tick();
        check("overflow_set", 80'(overflow), 80'd1);
        check("full_valid", 80'(pkt_if.packet_valid_o), 80'd1);
        for (int k = 0; k < 3; k++) begin
            check("head_stable", pkt_if.packet_o, mk_start(32'h0000_1000, 3'd0));
            tick();
        end
        pkt_if.packet_ready_i = 1'b1;
        wait_drain("drain_overflow");

        pkt_if.packet_ready_i = 1'b0;
        restart_start(32'h0000_3000, 3'd1, 1'b1);
        restart_start(32'h0000_3010, 3'd1, 1'b1);
        check("queued_valid", 80'(pkt_if.packet_valid_o), 80'd1);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("rst_valid", 80'(pkt_if.packet_valid_o), 80'd0);
        check("rst_overflow", 80'(overflow), 80'd0);
        check("rst_packet", pkt_if.packet_o, 80'd0);
        rst_n = 1'b1;
        pkt_if.packet_ready_i = 1'b1;
        tick();

        exp_q.push_back(mk_start(32'h0000_2000, 3'd1));
        retire(32'h0000_2000, NOP, 1'b0, 3'd1, 1'b0);
        wait_drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/trace_debugger.md
# trace_debugger

RISC-V instruction-trace encoder sitting beside the core's retirement port. It compresses the retired-instruction stream into fixed-width packets:
- a start packet with a full address;
- branch-map packets recording taken/not-taken outcomes of conditional branches;
- address packets after uninferable jumps;
- exception packets.

Packets are buffered in a small FIFO and drained through a valid/ready port toward trace storage.

## Interface
- FIFO_DEPTH, 4: packet FIFO entries (power of two, ≥2).
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- trace_enable_i  in  1  tracing enabled.
- ivalid_i  in  1  instruction retired (or trapped) this cycle.
- iexception_i  in  1  instruction/interrupt trap this cycle (qualified by ivalid_i).
- interrupt_i  in  1  trap is an interrupt.
- cause_i  in  5  trap cause.
- tval_i  in  32  trap value.
- priv_i  in  3  privilege level.
- iaddr_i  in  32  instruction address.
- instr_i  in  32  instruction word (compressed in [15:0]).
- compressed_i  in  1  instruction is 16-bit.
- packet_o  out  80  FIFO head packet.
- packet_valid_o  out  1  FIFO non-empty.
- packet_ready_i  in  1  consumer accepts head.
- overflow_o  out  1  sticky: a packet was dropped.

## Operation
- Packet type is packet_o[1:0]; unused bits are 0.
- 00 BRANCH_FULL: [6:2] count = 31, [37:7] map.
- 01 BRANCH_ADDR: [6:2] count, [37:7] map, [69:38] address.
- 10 START: [4:2] priv, [36:5] address.
- 11 EXCEPTION: [6:2] count, [37:7] map, [38] interrupt, [43:39] cause, [75:44] tval.
- Map bit i is the i-th resolved branch, bit 0 oldest. 1 = not taken, 0 = taken.
- Branch: 32-bit opcode 1100011, or compressed c.beqz/c.bnez ([1:0]=01, [15:13]=11x).
- Uninferable: jalr (opcode 1100111), c.jr/c.jalr ([1:0]=10, [15:13]=100, [6:2]=0, [11:7]≠0), or mret (0x30200073).
- State:
  - prev register: valid, addr, compressed, is_branch, is_uninf.
  - count (0–31) and map (31 bits).
  - start_pending flag, set by reset, by trace_enable_i low, and after an exception.
- Per cycle, with trace_enable_i=1 and ivalid_i=1, current instruction N:
  1. If prev.valid and prev.is_branch, append a bit: not taken iff N.addr == prev.addr + (prev.compressed ? 2 : 4).
  2. Priority, at most one packet per cycle:
     - N traps: EXCEPTION carrying the updated map; clear map; prev.valid←0; start_pending←1.
     - Else start_pending: START(priv_i, iaddr_i); start_pending←0.
     - Else prev.is_uninf: BRANCH_ADDR(count, map, iaddr_i); clear map.
     - Else count==31: BRANCH_FULL; clear map.
  3. If N is not a trap, prev←N.
- trace_enable_i=0: no packets; state as after reset. FIFO contents stay and keep draining.
- FIFO push when full:
  - Accepted if a pop occurs the same cycle.
  - Otherwise the packet is dropped and overflow_o←1.
- overflow_o clears only on reset.

## Timing
- Reset values: packet_o=0, packet_valid_o=0, overflow_o=0, FIFO empty, count=0, start_pending=1.
- Latency: a packet triggered in cycle t is on packet_o with packet_valid_o=1 from cycle t+1 when the FIFO was empty.
- Handshake: pop when packet_valid_o && packet_ready_i; packet_o holds stable while valid and not ready.
- Ordering: FIFO order equals generation order.
- Reset asserted mid-operation clears everything on the next edge, including queued packets.

## Test plan
- Enable, retire 0x80000000 with priv 3 → START type 10, address 0x80000000, priv 3, valid next cycle.
- After START:
  - beq at 0x100, next at 0x104 (not taken);
  - beq at 0x104, next at 0x200 (taken);
  - jalr at 0x200, next at 0x400.
  - → BRANCH_ADDR, count 2, map 0b01, address 0x400.
- 31 consecutive not-taken 4-byte branches → one BRANCH_FULL, map 0x7FFFFFFF; count returns to 0.
- Branch not taken, then an exception with cause 2, tval 0xDEAD, interrupt 0 → EXCEPTION, count 1, map 1. The next valid instruction at 0x8 → START, address 0x8.
- Hold packet_ready_i=0 and generate 5 packets with FIFO_DEPTH=4 → 4 queued, overflow_o=1, first packet stable on packet_o. Releasing ready drains them in order.
- Assert rst_ni=0 with queued packets → next cycle packet_valid_o=0 and overflow_o=0.
